axi4_mem_responder: RTL and testbench
=====================================

AXI4_MEM_RESPONDER -- requirements
Module: axi4_mem_responder

Interface
REQ-001 SHALL have parameter abits, default 10, meaning log2 of memory depth in 64-bit words (1024 words = 8 KB).
REQ-002 SHALL have port i_clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_xmsto  input  axi4_master_out_type  AW/W/AR channels and b_ready/r_ready from the system-bus master.
REQ-005 SHALL have port o_xmsti  output  axi4_master_in_type  aw_ready/w_ready/ar_ready, B and R channels returned to the master.

Function
REQ-006 SHALL be an AXI4 slave at the far end of the workgroup system-bus master port, backed by a 2^abits x 64-bit internal array.
REQ-007 SHALL run one FSM with states Idle, WData, WResp, RData, and SHALL have at most one transaction in flight.
REQ-008 In Idle: ar_ready=1; aw_ready=1 only when ar_valid=0; when AR and AW are valid in the same cycle, read wins and AW waits.
REQ-009 On AR handshake: latch addr, len, id, user, burst; go to RData; first r_valid in the next cycle (1-cycle latency).
REQ-010 In RData: drive one beat per cycle while r_ready=1; hold r_data/r_resp/r_last stable while r_valid=1 and r_ready=0; r_last=1 on beat len; return to Idle on last handshake.
REQ-011 On AW handshake: latch addr, len, id, user, burst; go to WData with w_ready=1.
REQ-012 In WData: on each w_valid beat, write bytes enabled by w_strb[7:0]; on the w_last handshake go to WResp; w_last is the sole burst terminator, beat count is not checked.
REQ-013 In WResp: b_valid=1 with the latched b_id/b_user; hold until b_ready=1, then Idle.
REQ-014 Word index = addr[abits+2:3]; address bits [2:0] ignored; sizes below 64 bits rely on w_strb.
REQ-015 Burst FIXED: index constant; INCR: index+1 per beat, wrapping modulo 2^abits; WRAP: treated as INCR with resp SLVERR on every beat (writes still performed).
REQ-016 Any address bit above abits+2 nonzero: resp DECERR, write suppressed, r_data=0.
REQ-017 Otherwise resp OKAY; r_id/r_user equal the latched AR id/user.
REQ-018 Read-during-write to the same word is impossible by construction (single transaction); array is a registered-read RAM.

Reset
REQ-019 With i_rst=1 at a clock edge: state=Idle; all ready/valid outputs 0; r_last=0, r_resp=0, b_resp=0, r_data=0.
REQ-020 Reset mid-burst SHALL abandon the transaction with no B/R completion; array contents retained unless REQ-022 applies.
REQ-021 All ready signals SHALL be 0 during the cycle i_rst=1 and SHALL become 1 no earlier than the first cycle after reset deassertion.

Configuration
REQ-022 With macro AXI4_MEM_RESPONDER_ZEROINIT_EN defined: after reset deassertion an init state SHALL write 0 to one word per cycle (2^abits cycles) with all ready outputs 0, then enter Idle.
REQ-023 Without AXI4_MEM_RESPONDER_ZEROINIT_EN: no init state; Idle on the first cycle after reset; array content undefined until written.

Verification
REQ-024 INCR write, addr 0x40, len=3, data 0x11..,0x22..,0x33..,0x44.., strb 0xFF -> single b_valid OKAY; INCR read, addr 0x40, len=3 -> the same 4 words returned, r_last on beat 3.
REQ-025 Read with r_ready toggling 1/0 each cycle -> r_data held stable while stalled, no beat lost or duplicated.
REQ-026 AR and AW valid in the same cycle -> AR accepted first, aw_ready=0 until read completes, then AW accepted.
REQ-027 Write 0xFFFF_FFFF_FFFF_FFFF, then write 0 with strb 0x0F, read back -> 0xFFFF_FFFF_0000_0000; read at addr 1<<(abits+3) -> DECERR, data 0.
REQ-028 i_rst asserted during the second beat of a len=7 read -> r_valid=0 next cycle, no further beats; new read after reset correct; with ZEROINIT_EN, ar_ready=0 for exactly 1024 cycles, then reads return 0.

Source files
------------

// File: rtl/axi4_mem_responder.sv
// axi4_mem_responder: AXI4 slave backed by a 2^abits x 64-bit registered-read
// array, one transaction in flight (Idle / WData / WResp / RData).
// Optional build macro AXI4_MEM_RESPONDER_ZEROINIT_EN adds an init state that
// clears the array one word per cycle after reset before accepting traffic.
//
// Handshake rule for every channel: a transfer happens on a rising edge where
// both valid and ready are 1. The source holds payload stable while valid=1
// and ready=0, and never drops valid before the transfer. Ready may depend on
// the other side's valid (aw_ready is blocked by a same-cycle ar_valid).

package axi4_mem_responder_pkg;

  typedef struct packed {
    logic        aw_valid;
    logic [47:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic [4:0]  aw_id;
    logic        aw_user;
    logic        w_valid;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_last;
    logic        b_ready;
    logic        ar_valid;
    logic [47:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic [4:0]  ar_id;
    logic        ar_user;
    logic        r_ready;
  } axi4_master_out_type;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    logic        b_valid;
    logic [1:0]  b_resp;
    logic [4:0]  b_id;
    logic        b_user;
    logic        ar_ready;
    logic        r_valid;
    logic [1:0]  r_resp;
    logic [63:0] r_data;
    logic        r_last;
    logic [4:0]  r_id;
    logic        r_user;
  } axi4_master_in_type;

endpackage

module axi4_mem_responder
  import axi4_mem_responder_pkg::*;
#(
  parameter int abits = 10
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  axi4_master_out_type i_xmsto,
  output axi4_master_in_type  o_xmsti,
  output logic [2:0]          dbg_state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WDATA = 3'd1;
  localparam logic [2:0] ST_WRESP = 3'd2;
  localparam logic [2:0] ST_RDATA = 3'd3;

`ifdef AXI4_MEM_RESPONDER_ZEROINIT_EN
  localparam logic [2:0] ST_INIT  = 3'd4;
  localparam logic [2:0] ST_RESET = ST_INIT;
`else
  localparam logic [2:0] ST_RESET = ST_IDLE;
`endif

  // INCR is the "anything else" case of the index update, so only FIXED
  // and WRAP need names.
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  logic [63:0] mem [0:(1<<abits)-1];

  logic [2:0]       state;
  logic [abits-1:0] idx_q;
  logic [7:0]       beat_q;
  logic [7:0]       len_q;
  logic [4:0]       id_q;
  logic             user_q;
  logic [1:0]       burst_q;
  logic             decerr_q;
  logic [63:0]      r_data_q;

`ifdef AXI4_MEM_RESPONDER_ZEROINIT_EN
  logic [abits-1:0] init_idx_q;
`endif

  logic [abits-1:0] ar_idx;
  logic [abits-1:0] aw_idx;
  logic             ar_decerr;
  logic             aw_decerr;
  logic [abits-1:0] nxt_idx;
  logic [1:0]       resp_cur;

  logic             mem_we;
  logic [abits-1:0] mem_widx;
  logic [63:0]      mem_wdata;
  logic [7:0]       mem_wstrb;

  // Byte offset and size are not needed: sub-word writes are expressed by w_strb.
  logic unused_bits;
  assign unused_bits = ^{i_xmsto.aw_size, i_xmsto.ar_size,
                         i_xmsto.aw_addr[2:0], i_xmsto.ar_addr[2:0]};

  // Word index and out-of-range detection for incoming address phases.
  assign ar_idx    = i_xmsto.ar_addr[abits+2:3];
  assign aw_idx    = i_xmsto.aw_addr[abits+2:3];
  assign ar_decerr = (i_xmsto.ar_addr >> (abits + 3)) != '0;
  assign aw_decerr = (i_xmsto.aw_addr >> (abits + 3)) != '0;

  // FIXED holds the index; INCR and WRAP advance it, wrapping inside the array.
  assign nxt_idx = (burst_q == BURST_FIXED) ? idx_q : idx_q + 1'b1;

  // DECERR dominates; a WRAP burst is served as INCR but flagged SLVERR.
  assign resp_cur = decerr_q ? RESP_DECERR :
                    (burst_q == BURST_WRAP) ? RESP_SLVERR : RESP_OKAY;

  assign dbg_state = state;

  // Channel outputs: readies are forced low while reset is asserted.
  always_comb begin
    o_xmsti          = '0;
    o_xmsti.ar_ready = (state == ST_IDLE) && !i_rst;
    o_xmsti.aw_ready = (state == ST_IDLE) && !i_xmsto.ar_valid && !i_rst;
    o_xmsti.w_ready  = (state == ST_WDATA) && !i_rst;
    o_xmsti.b_valid  = (state == ST_WRESP);
    o_xmsti.b_resp   = (state == ST_WRESP) ? resp_cur : RESP_OKAY;
    o_xmsti.b_id     = id_q;
    o_xmsti.b_user   = user_q;
    o_xmsti.r_valid  = (state == ST_RDATA);
    o_xmsti.r_resp   = (state == ST_RDATA) ? resp_cur : RESP_OKAY;
    o_xmsti.r_data   = r_data_q;
    o_xmsti.r_last   = (state == ST_RDATA) && (beat_q == len_q);
    o_xmsti.r_id     = id_q;
    o_xmsti.r_user   = user_q;
  end

  // Array write port: burst data beats, or zero fill during init.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = idx_q;
    mem_wdata = i_xmsto.w_data;
    mem_wstrb = i_xmsto.w_strb;
    if (!i_rst && (state == ST_WDATA) && i_xmsto.w_valid && !decerr_q) begin
      mem_we = 1'b1;
    end
`ifdef AXI4_MEM_RESPONDER_ZEROINIT_EN
    if (!i_rst && (state == ST_INIT)) begin
      mem_we    = 1'b1;
      mem_widx  = init_idx_q;
      mem_wdata = '0;
      mem_wstrb = 8'hFF;
    end
`endif
  end

  // Byte-enabled array write; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (mem_wstrb[b]) begin
          mem[mem_widx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Transaction FSM; the read word is fetched on the edge that accepts AR or
  // an R beat, so r_data is already registered when r_valid is shown.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_RESET;
      idx_q    <= '0;
      beat_q   <= '0;
      len_q    <= '0;
      id_q     <= '0;
      user_q   <= 1'b0;
      burst_q  <= '0;
      decerr_q <= 1'b0;
      r_data_q <= '0;
`ifdef AXI4_MEM_RESPONDER_ZEROINIT_EN
      init_idx_q <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_xmsto.ar_valid) begin
            idx_q    <= ar_idx;
            len_q    <= i_xmsto.ar_len;
            id_q     <= i_xmsto.ar_id;
            user_q   <= i_xmsto.ar_user;
            burst_q  <= i_xmsto.ar_burst;
            decerr_q <= ar_decerr;
            beat_q   <= '0;
            r_data_q <= ar_decerr ? '0 : mem[ar_idx];
            state    <= ST_RDATA;
          end else if (i_xmsto.aw_valid) begin
            idx_q    <= aw_idx;
            len_q    <= i_xmsto.aw_len;
            id_q     <= i_xmsto.aw_id;
            user_q   <= i_xmsto.aw_user;
            burst_q  <= i_xmsto.aw_burst;
            decerr_q <= aw_decerr;
            beat_q   <= '0;
            state    <= ST_WDATA;
          end
        end
        ST_RDATA: begin
          if (i_xmsto.r_ready) begin
            if (beat_q == len_q) begin
              state <= ST_IDLE;
            end else begin
              beat_q   <= beat_q + 8'd1;
              idx_q    <= nxt_idx;
              r_data_q <= decerr_q ? '0 : mem[nxt_idx];
            end
          end
        end
        ST_WDATA: begin
          if (i_xmsto.w_valid) begin
            idx_q <= nxt_idx;
            if (i_xmsto.w_last) begin
              state <= ST_WRESP;
            end
          end
        end
        ST_WRESP: begin
          if (i_xmsto.b_ready) begin
            state <= ST_IDLE;
          end
        end
`ifdef AXI4_MEM_RESPONDER_ZEROINIT_EN
        ST_INIT: begin
          init_idx_q <= init_idx_q + 1'b1;
          if (&init_idx_q) begin
            state <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder: drives the master side of AXI4 on
// the falling edge, samples 1 ns later, compares read beats against exp_q.
`timescale 1ns/1ps
module tb_axi4_mem_responder;
  import axi4_mem_responder_pkg::*;

  localparam int ABITS = 10;

`ifdef AXI4_MEM_RESPONDER_ZEROINIT_EN
  localparam int         EXP_INIT_CYCLES = 1 << ABITS;
  localparam logic [2:0] EXP_RST_STATE   = 3'd4;
`else
  localparam int         EXP_INIT_CYCLES = 0;
  localparam logic [2:0] EXP_RST_STATE   = 3'd0;
`endif

  localparam logic [63:0] D0 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] D1 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] D2 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] D3 = 64'h4444_4444_4444_4444;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_master_out_type mo;
  axi4_master_in_type  mi;
  logic [2:0]          dbg_state;

  axi4_mem_responder #(.abits(ABITS)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_xmsto   (mo),
    .o_xmsti   (mi),
    .dbg_state (dbg_state)
  );

  // scoreboard
  logic [63:0] exp_q[$];
  logic [63:0] wd [0:15];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: each starts and ends on a falling edge
  task automatic do_ar(input logic [47:0] addr, input logic [7:0] len,
                       input logic [1:0] burst, input logic [4:0] id);
    bit ok = 0;
    mo.ar_valid = 1'b1; mo.ar_addr = addr; mo.ar_len = len;
    mo.ar_burst = burst; mo.ar_id = id; mo.ar_user = id[0]; mo.ar_size = 3'd3;
    for (int c = 0; c < 3000; c++) begin
      #1;
      if (mi.ar_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    mo.ar_valid = 1'b0;
    if (!ok) check("ar_timeout", 0, 1);
  endtask

  task automatic do_r(input int len, input bit toggle, input logic [1:0] exp_resp,
                      input logic [4:0] exp_id);
    int beats = 0;
    bit done = 0;
    bit stalled = 0;
    logic [63:0] held = '0;
    check("r_first_cycle", mi.r_valid, 1'b1);
    for (int c = 0; c < 600 && !done; c++) begin
      mo.r_ready = toggle ? (c % 2 == 1) : 1'b1;
      #1;
      if (mi.r_valid) begin
        if (stalled) check("r_hold", mi.r_data, held);
        if (mo.r_ready) begin
          if (exp_q.size() == 0) check("r_extra_beat", 1, 0);
          else check("r_data", mi.r_data, exp_q.pop_front());
          check("r_resp", mi.r_resp, exp_resp);
          check("r_id", mi.r_id, exp_id);
          check("r_last", mi.r_last, beats == len);
          beats++;
          if (mi.r_last) done = 1;
          stalled = 0;
        end else begin
          stalled = 1;
          held = mi.r_data;
        end
      end
      @(negedge clk);
    end
    mo.r_ready = 1'b0;
    check("r_beats", beats, len + 1);
    exp_q.delete();
  endtask

  task automatic axi_read(input logic [47:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [4:0] id,
                          input bit toggle, input logic [1:0] exp_resp);
    do_ar(addr, len, burst, id);
    do_r(len, toggle, exp_resp, id);
  endtask

  task automatic do_aw(input logic [47:0] addr, input logic [7:0] len,
                       input logic [1:0] burst, input logic [4:0] id);
    bit ok = 0;
    mo.aw_valid = 1'b1; mo.aw_addr = addr; mo.aw_len = len;
    mo.aw_burst = burst; mo.aw_id = id; mo.aw_user = id[0]; mo.aw_size = 3'd3;
    for (int c = 0; c < 3000; c++) begin
      #1;
      if (mi.aw_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    mo.aw_valid = 1'b0;
    if (!ok) check("aw_timeout", 0, 1);
  endtask

  task automatic do_w(input int nbeats, input logic [7:0] strb);
    for (int b = 0; b < nbeats; b++) begin
      bit ok = 0;
      mo.w_valid = 1'b1; mo.w_data = wd[b]; mo.w_strb = strb;
      mo.w_last = (b == nbeats - 1);
      for (int c = 0; c < 100; c++) begin
        #1;
        if (mi.w_ready) begin ok = 1; break; end
        @(negedge clk);
      end
      @(negedge clk);
      if (!ok) check("w_timeout", 0, 1);
    end
    mo.w_valid = 1'b0;
    mo.w_last  = 1'b0;
  endtask

  task automatic do_b(input logic [1:0] exp_resp, input logic [4:0] exp_id);
    bit got = 0;
    mo.b_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (mi.b_valid) begin
        got = 1;
        check("b_resp", mi.b_resp, exp_resp);
        check("b_id", mi.b_id, exp_id);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    mo.b_ready = 1'b0;
    if (!got) check("b_timeout", 0, 1);
    #1 check("b_single", mi.b_valid, 1'b0);
    @(negedge clk);
  endtask

  task automatic axi_write(input logic [47:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [4:0] id,
                           input logic [7:0] strb, input logic [1:0] exp_resp);
    do_aw(addr, len, burst, id);
    do_w(len + 1, strb);
    do_b(exp_resp, id);
  endtask

  // watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    int n;
    bit idle_ok;
    mo  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", {mi.ar_ready, mi.aw_ready, mi.w_ready}, 3'b000);
    check("rst_valid", {mi.r_valid, mi.b_valid}, 2'b00);
    check("rst_r_data", mi.r_data, 64'h0);
    check("rst_resp_last", {mi.r_last, mi.r_resp, mi.b_resp}, 5'b0);
    check("rst_state", dbg_state, EXP_RST_STATE);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int c = 0; c < 3000; c++) begin
      #1;
      if (mi.ar_ready) break;
      n++;
      @(negedge clk);
    end
    check("init_cycles", n, EXP_INIT_CYCLES);
    @(negedge clk);

`ifdef AXI4_MEM_RESPONDER_ZEROINIT_EN
    exp_q.push_back(64'h0);
    axi_read(48'h800, 8'd0, 2'd1, 5'd1, 1'b0, 2'd0);
`endif

    // INCR write / read-back
    wd[0] = D0; wd[1] = D1; wd[2] = D2; wd[3] = D3;
    axi_write(48'h40, 8'd3, 2'd1, 5'd2, 8'hFF, 2'd0);
    exp_q.push_back(D0); exp_q.push_back(D1); exp_q.push_back(D2); exp_q.push_back(D3);
    axi_read(48'h40, 8'd3, 2'd1, 5'd5, 1'b0, 2'd0);

    // read with r_ready toggling
    exp_q.push_back(D0); exp_q.push_back(D1); exp_q.push_back(D2); exp_q.push_back(D3);
    axi_read(48'h40, 8'd3, 2'd1, 5'd7, 1'b1, 2'd0);

    // AR and AW together: read first, AW held off until read completes
    mo.ar_valid = 1'b1; mo.ar_addr = 48'h40; mo.ar_len = 8'd0; mo.ar_burst = 2'd1;
    mo.ar_id = 5'd3; mo.ar_user = 1'b1;
    mo.aw_valid = 1'b1; mo.aw_addr = 48'h500; mo.aw_len = 8'd0; mo.aw_burst = 2'd1;
    mo.aw_id = 5'd4; mo.aw_user = 1'b0;
    #1;
    check("conc_ar_ready", mi.ar_ready, 1'b1);
    check("conc_aw_blocked", mi.aw_ready, 1'b0);
    @(negedge clk);
    mo.ar_valid = 1'b0;
    #1 check("conc_aw_wait", mi.aw_ready, 1'b0);
    exp_q.push_back(D0);
    do_r(0, 1'b0, 2'd0, 5'd3);
    #1 check("conc_aw_go", mi.aw_ready, 1'b1);
    @(negedge clk);
    mo.aw_valid = 1'b0;
    wd[0] = 64'hABCD_0123_4567_89EF;
    do_w(1, 8'hFF);
    do_b(2'd0, 5'd4);
    exp_q.push_back(64'hABCD_0123_4567_89EF);
    axi_read(48'h500, 8'd0, 2'd1, 5'd4, 1'b0, 2'd0);

    // byte strobes
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    axi_write(48'h100, 8'd0, 2'd1, 5'd8, 8'hFF, 2'd0);
    wd[0] = 64'h0;
    axi_write(48'h100, 8'd0, 2'd1, 5'd8, 8'h0F, 2'd0);
    exp_q.push_back(64'hFFFF_FFFF_0000_0000);
    axi_read(48'h100, 8'd0, 2'd1, 5'd9, 1'b0, 2'd0);

    // out-of-range address: DECERR, zero data, write suppressed
    exp_q.push_back(64'h0);
    axi_read(48'h1 << (ABITS + 3), 8'd0, 2'd1, 5'd10, 1'b0, 2'd3);
    wd[0] = 64'hDEAD_BEEF_DEAD_BEEF;
    axi_write((48'h1 << (ABITS + 3)) | 48'h40, 8'd0, 2'd1, 5'd11, 8'hFF, 2'd3);
    exp_q.push_back(D0);
    axi_read(48'h40, 8'd0, 2'd1, 5'd12, 1'b0, 2'd0);

    // FIXED burst keeps one word
    wd[0] = 64'hAAAA_0000_0000_0001; wd[1] = 64'hBBBB_0000_0000_0002;
    axi_write(48'h200, 8'd1, 2'd0, 5'd13, 8'hFF, 2'd0);
    exp_q.push_back(64'hBBBB_0000_0000_0002); exp_q.push_back(64'hBBBB_0000_0000_0002);
    axi_read(48'h200, 8'd1, 2'd0, 5'd13, 1'b0, 2'd0);

    // WRAP burst: INCR behaviour with SLVERR
    wd[0] = 64'hC0C0_C0C0_0000_0003; wd[1] = 64'hD0D0_D0D0_0000_0004;
    axi_write(48'h300, 8'd1, 2'd2, 5'd14, 8'hFF, 2'd2);
    exp_q.push_back(64'hC0C0_C0C0_0000_0003); exp_q.push_back(64'hD0D0_D0D0_0000_0004);
    axi_read(48'h300, 8'd1, 2'd1, 5'd15, 1'b0, 2'd0);
    exp_q.push_back(64'hC0C0_C0C0_0000_0003);
    axi_read(48'h300, 8'd0, 2'd2, 5'd16, 1'b0, 2'd2);

    // INCR index wraps from the last word to word 0
    wd[0] = 64'hEEEE_EEEE_EEEE_0005; wd[1] = 64'hFFFF_0000_FFFF_0006;
    axi_write(48'h1FF8, 8'd1, 2'd1, 5'd17, 8'hFF, 2'd0);
    exp_q.push_back(64'hEEEE_EEEE_EEEE_0005); exp_q.push_back(64'hFFFF_0000_FFFF_0006);
    axi_read(48'h1FF8, 8'd1, 2'd1, 5'd18, 1'b0, 2'd0);
    exp_q.push_back(64'hFFFF_0000_FFFF_0006);
    axi_read(48'h0, 8'd0, 2'd1, 5'd19, 1'b0, 2'd0);

    // reset during the second beat of a len=7 read
    for (int k = 0; k < 8; k++) wd[k] = 64'h0400_0000_0000_0000 + 64'(k * 17 + 1);
    axi_write(48'h400, 8'd7, 2'd1, 5'd20, 8'hFF, 2'd0);
    do_ar(48'h400, 8'd7, 2'd1, 5'd21);
    mo.r_ready = 1'b1;
    #1 check("mid_beat0", mi.r_data, wd[0]);
    @(negedge clk);
    #1 check("mid_beat1", mi.r_data, wd[1]);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_r_valid", mi.r_valid, 1'b0);
    check("mid_rst_ar_ready", mi.ar_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle_ok = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (mi.r_valid) idle_ok = 0;
      @(negedge clk);
    end
    mo.r_ready = 1'b0;
    check("mid_no_more_beats", idle_ok, 1'b1);
`ifdef AXI4_MEM_RESPONDER_ZEROINIT_EN
    exp_q.push_back(64'h0); exp_q.push_back(64'h0);
`else
    exp_q.push_back(wd[0]); exp_q.push_back(wd[1]);
`endif
    axi_read(48'h400, 8'd1, 2'd1, 5'd22, 1'b0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
